issue_ctrl: RTL and testbench

In-order dual-issue scheduler between the decode stage's fetch buffer and the register-read/execute pipes. Each cycle it inspects the two decoded slots and drives the decode stage's `read_en` (00 / 01 / 11). Its decision uses:
- a per-register busy scoreboard,
- structural limits (one memory pipe),
- serialization rules for CSR/barrier/privileged ops.

It also tracks outstanding register writes until writeback.

---
 rtl/issue_if.sv | 33 +++
 rtl/issue_ctrl.sv | 99 +++++++++
 tb/tb_issue_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/issue_if.sv
// Decode-to-issue handshake bundle: decoded slots, flush/stall/writeback/serial inputs, and the issue decision back out.
interface issue_if #(parameter int NREG = 32);
  logic            flush;
  logic            stall_in;
  logic            valid0, valid1;
  logic [4:0]      rd0, rj0, rk0, rd1, rj1, rk1;
  logic            wr_rd0, wr_rd1;
  logic            use_rj0, use_rk0, use_rj1, use_rk1;
  logic            is_mem0, is_mem1;
  logic            is_serial0, is_serial1;
  logic            wb_en0, wb_en1;
  logic [4:0]      wb_rd0, wb_rd1;
  logic            serial_done;
  logic [1:0]      read_en;
  logic            issue0, issue1;
  logic [NREG-1:0] busy_o;

  modport master (
    output flush, stall_in, valid0, valid1, rd0, rj0, rk0, rd1, rj1, rk1,
           wr_rd0, wr_rd1, use_rj0, use_rk0, use_rj1, use_rk1,
           is_mem0, is_mem1, is_serial0, is_serial1,
           wb_en0, wb_en1, wb_rd0, wb_rd1, serial_done,
    input  read_en, issue0, issue1, busy_o
  );

  modport slave (
    input  flush, stall_in, valid0, valid1, rd0, rj0, rk0, rd1, rj1, rk1,
           wr_rd0, wr_rd1, use_rj0, use_rk0, use_rj1, use_rk1,
           is_mem0, is_mem1, is_serial0, is_serial1,
           wb_en0, wb_en1, wb_rd0, wb_rd1, serial_done,
    output read_en, issue0, issue1, busy_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order dual-issue scheduler: busy scoreboard, one memory pipe, serialization FSM (RUN/DRAIN/SER_WAIT).
// Issue is combinational from inputs and registered state; CLAP_DUAL_ISSUE_EN enables slot 1.
module issue_ctrl #(
  parameter int NREG = 32
) (
  input logic   clk,
  input logic   rstn,
  issue_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, SER_WAIT} state_t;

  state_t          state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            ok0, can0, issue0, issue1;

  // Source and destination of slot 0 must be free (RAW and WAW against in-flight writes).
  always_comb begin
    ok0 = 1'b1;
    if (bus.use_rj0 && busy_q[bus.rj0]) ok0 = 1'b0;
    if (bus.use_rk0 && busy_q[bus.rk0]) ok0 = 1'b0;
    if (bus.wr_rd0 && busy_q[bus.rd0])  ok0 = 1'b0;
  end

  assign can0 = rstn && bus.valid0 && !bus.stall_in && !bus.flush;

  always_comb begin
    issue0  = 1'b0;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.valid0 && bus.is_serial0) state_d = DRAIN;
        else                              issue0  = can0 && ok0;
      end
      DRAIN: begin
        if (busy_q == '0 && can0) begin
          issue0  = 1'b1;
          state_d = SER_WAIT;
        end
      end
      SER_WAIT: begin
        if (bus.serial_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (bus.flush) state_d = RUN;
  end

`ifdef CLAP_DUAL_ISSUE_EN
  logic ok1, raw01, waw01;

  always_comb begin
    ok1 = 1'b1;
    if (bus.use_rj1 && busy_q[bus.rj1]) ok1 = 1'b0;
    if (bus.use_rk1 && busy_q[bus.rk1]) ok1 = 1'b0;
    if (bus.wr_rd1 && busy_q[bus.rd1])  ok1 = 1'b0;
  end

  assign raw01 = bus.wr_rd0 && (bus.rd0 != 5'd0) &&
                 ((bus.use_rj1 && bus.rj1 == bus.rd0) || (bus.use_rk1 && bus.rk1 == bus.rd0));
  assign waw01 = bus.wr_rd0 && bus.wr_rd1 && (bus.rd0 == bus.rd1) && (bus.rd0 != 5'd0);

  assign issue1 = issue0 && (state_q == RUN) && bus.valid1 && ok1 &&
                  !bus.is_serial0 && !bus.is_serial1 &&
                  !(bus.is_mem0 && bus.is_mem1) && !raw01 && !waw01;
`else
  logic unused_slot1;
  assign unused_slot1 = ^{bus.valid1, bus.rj1, bus.rk1, bus.use_rj1, bus.use_rk1,
                          bus.is_mem0, bus.is_mem1, bus.is_serial1};
  assign issue1 = 1'b0;
`endif

  // Clears before sets so a same-cycle issue of a written-back register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en0) busy_d[bus.wb_rd0] = 1'b0;
    if (bus.wb_en1) busy_d[bus.wb_rd1] = 1'b0;
    if (issue0 && bus.wr_rd0) busy_d[bus.rd0] = 1'b1;
    if (issue1 && bus.wr_rd1) busy_d[bus.rd1] = 1'b1;
    busy_d[0] = 1'b0;
    if (bus.flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q  <= '0;
      state_q <= RUN;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
    end
  end

  assign bus.issue0  = issue0;
  assign bus.issue1  = issue1;
  assign bus.read_en = {issue1, issue0};
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed-vector bench for issue_ctrl; expectations follow the CLAP_DUAL_ISSUE_EN build setting.
module tb_issue_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef CLAP_DUAL_ISSUE_EN
  localparam logic [1:0] PAIR = 2'b11;
  localparam logic       DUAL = 1'b1;
`else
  localparam logic [1:0] PAIR = 2'b01;
  localparam logic       DUAL = 1'b0;
`endif

  issue_if #(.NREG(32)) bus ();
  issue_ctrl #(.NREG(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.stall_in = 0; bus.serial_done = 0;
    bus.valid0 = 0; bus.rd0 = 0; bus.rj0 = 0; bus.rk0 = 0;
    bus.wr_rd0 = 0; bus.use_rj0 = 0; bus.use_rk0 = 0; bus.is_mem0 = 0; bus.is_serial0 = 0;
    bus.valid1 = 0; bus.rd1 = 0; bus.rj1 = 0; bus.rk1 = 0;
    bus.wr_rd1 = 0; bus.use_rj1 = 0; bus.use_rk1 = 0; bus.is_mem1 = 0; bus.is_serial1 = 0;
    bus.wb_en0 = 0; bus.wb_en1 = 0; bus.wb_rd0 = 0; bus.wb_rd1 = 0;
  endtask

  task automatic s0(input logic v, input logic [4:0] rd, rj, rk,
                    input logic wr, urj, urk, mem, ser);
    bus.valid0 = v; bus.rd0 = rd; bus.rj0 = rj; bus.rk0 = rk; bus.wr_rd0 = wr;
    bus.use_rj0 = urj; bus.use_rk0 = urk; bus.is_mem0 = mem; bus.is_serial0 = ser;
  endtask

  task automatic s1(input logic v, input logic [4:0] rd, rj, rk,
                    input logic wr, urj, urk, mem, ser);
    bus.valid1 = v; bus.rd1 = rd; bus.rj1 = rj; bus.rk1 = rk; bus.wr_rd1 = wr;
    bus.use_rj1 = urj; bus.use_rk1 = urk; bus.is_mem1 = mem; bus.is_serial1 = ser;
  endtask

  task automatic test_reset();
    idle(); rstn = 0;
    s0(1, 4, 1, 2, 1, 1, 1, 0, 0);
    tick(); #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL reset_read_en got=%b exp=00", bus.read_en); end
    checks++; if (bus.issue0 !== 1'b0) begin failures++; $display("FAIL reset_issue0 got=%b exp=0", bus.issue0); end
    checks++; if (bus.busy_o !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy_o); end
    idle(); rstn = 1; tick();
  endtask

  task automatic test_independent_pair();
    s0(1, 4, 1, 2, 1, 1, 1, 0, 0); s1(1, 5, 3, 6, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== PAIR) begin failures++; $display("FAIL pair_read_en got=%b exp=%b", bus.read_en, PAIR); end
    checks++; if (bus.issue1 !== PAIR[1]) begin failures++; $display("FAIL pair_issue1 got=%b exp=%b", bus.issue1, PAIR[1]); end
    tick(); idle(); #1;
    checks++; if (bus.busy_o !== (DUAL ? 32'h30 : 32'h10)) begin failures++; $display("FAIL pair_busy got=%h exp=%h", bus.busy_o, DUAL ? 32'h30 : 32'h10); end
    bus.wb_en0 = 1; bus.wb_rd0 = 4; bus.wb_en1 = 1; bus.wb_rd1 = 5;
    tick(); idle(); #1;
    checks++; if (bus.busy_o !== 32'h0) begin failures++; $display("FAIL pair_wb_clear got=%h exp=0", bus.busy_o); end
    tick();
  endtask

  task automatic test_intra_raw();
    s0(1, 7, 1, 2, 1, 1, 1, 0, 0); s1(1, 8, 7, 0, 1, 1, 0, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL raw_pair got=%b exp=01", bus.read_en); end
    tick(); idle(); s0(1, 8, 7, 0, 1, 1, 0, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL raw_blocked got=%b exp=00", bus.read_en); end
    tick(); bus.wb_en0 = 1; bus.wb_rd0 = 7; #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL raw_no_bypass got=%b exp=00", bus.read_en); end
    tick(); bus.wb_en0 = 0; #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL raw_unblocked got=%b exp=01", bus.read_en); end
    tick(); idle(); bus.wb_en0 = 1; bus.wb_rd0 = 8; bus.wb_en1 = 1; bus.wb_rd1 = 8; #1;
    checks++; if (bus.busy_o !== 32'h100) begin failures++; $display("FAIL raw_busy8 got=%h exp=100", bus.busy_o); end
    tick(); idle(); #1;
    checks++; if (bus.busy_o !== 32'h0) begin failures++; $display("FAIL raw_dup_wb got=%h exp=0", bus.busy_o); end
    tick();
  endtask

  task automatic test_mem_pair();
    s0(1, 0, 1, 2, 0, 1, 1, 1, 0); s1(1, 0, 3, 4, 0, 1, 1, 1, 0); #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL mem_mem got=%b exp=01", bus.read_en); end
    tick(); bus.is_mem1 = 0; #1;
    checks++; if (bus.read_en !== PAIR) begin failures++; $display("FAIL mem_alu got=%b exp=%b", bus.read_en, PAIR); end
    tick(); idle();
  endtask

  task automatic test_serial();
    s0(1, 3, 1, 2, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL ser_setup got=%b exp=01", bus.read_en); end
    tick(); idle(); s0(1, 0, 0, 0, 0, 0, 0, 0, 1); s1(1, 0, 1, 2, 0, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL ser_enter_drain got=%b exp=00", bus.read_en); end
    tick(); bus.wb_en0 = 1; bus.wb_rd0 = 3; #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL ser_drain_busy got=%b exp=00", bus.read_en); end
    tick(); bus.wb_en0 = 0; #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL ser_drain_issue got=%b exp=01", bus.read_en); end
    tick(); s0(1, 0, 1, 2, 0, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL ser_wait got=%b exp=00", bus.read_en); end
    tick(); bus.serial_done = 1; #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL ser_done_cycle got=%b exp=00", bus.read_en); end
    tick(); bus.serial_done = 0; #1;
    checks++; if (bus.read_en !== PAIR) begin failures++; $display("FAIL ser_resume got=%b exp=%b", bus.read_en, PAIR); end
    tick(); idle();
  endtask

  task automatic test_flush();
    s0(1, 9, 1, 2, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL flush_setup got=%b exp=01", bus.read_en); end
    tick(); idle(); s0(1, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL flush_drain got=%b exp=00", bus.read_en); end
    tick(); bus.flush = 1; #1;
    checks++; if (bus.busy_o !== 32'h200) begin failures++; $display("FAIL flush_busy9 got=%h exp=200", bus.busy_o); end
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL flush_cycle got=%b exp=00", bus.read_en); end
    tick(); idle(); s0(1, 4, 1, 2, 1, 1, 1, 0, 0); s1(1, 5, 3, 6, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.busy_o !== 32'h0) begin failures++; $display("FAIL flush_clear got=%h exp=0", bus.busy_o); end
    checks++; if (bus.read_en !== PAIR) begin failures++; $display("FAIL flush_run_pair got=%b exp=%b", bus.read_en, PAIR); end
    tick(); idle(); bus.wb_en0 = 1; bus.wb_rd0 = 4; bus.wb_en1 = 1; bus.wb_rd1 = 5;
    tick(); idle(); bus.serial_done = 1; s0(1, 0, 1, 2, 0, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL stray_done got=%b exp=01", bus.read_en); end
    tick(); bus.serial_done = 0; #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL stray_done_after got=%b exp=01", bus.read_en); end
    tick(); idle();
  endtask

  task automatic test_set_wins();
    s0(1, 10, 1, 2, 1, 1, 1, 0, 0); bus.wb_en1 = 1; bus.wb_rd1 = 10; #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL setwin_issue got=%b exp=01", bus.read_en); end
    tick(); idle(); s0(1, 0, 1, 2, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.busy_o !== 32'h400) begin failures++; $display("FAIL setwin_busy got=%h exp=400", bus.busy_o); end
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL r0_write_issue got=%b exp=01", bus.read_en); end
    tick(); idle(); s0(1, 10, 1, 2, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.busy_o !== 32'h400) begin failures++; $display("FAIL r0_never_busy got=%h exp=400", bus.busy_o); end
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL waw_block got=%b exp=00", bus.read_en); end
    tick(); idle(); bus.wb_en0 = 1; bus.wb_rd0 = 10;
    tick(); idle(); #1;
    checks++; if (bus.busy_o !== 32'h0) begin failures++; $display("FAIL setwin_clear got=%h exp=0", bus.busy_o); end
    tick();
  endtask

  task automatic test_misc();
    s1(1, 5, 3, 6, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL valid1_only got=%b exp=00", bus.read_en); end
    tick(); idle(); s0(1, 4, 1, 2, 1, 1, 1, 0, 0); s1(1, 5, 3, 6, 1, 1, 1, 0, 0); bus.stall_in = 1; #1;
    checks++; if (bus.read_en !== 2'b00) begin failures++; $display("FAIL stall got=%b exp=00", bus.read_en); end
    tick(); idle(); s0(1, 13, 1, 2, 1, 1, 1, 0, 0); s1(1, 13, 3, 4, 1, 1, 1, 0, 0); #1;
    checks++; if (bus.read_en !== 2'b01) begin failures++; $display("FAIL intra_waw got=%b exp=01", bus.read_en); end
    tick(); idle(); #1;
    checks++; if (bus.busy_o !== 32'h2000) begin failures++; $display("FAIL intra_waw_busy got=%h exp=2000", bus.busy_o); end
    bus.wb_en0 = 1; bus.wb_rd0 = 13;
    tick(); idle(); #1;
    checks++; if (bus.busy_o !== 32'h0) begin failures++; $display("FAIL final_busy got=%h exp=0", bus.busy_o); end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_independent_pair();
    test_intra_raw();
    test_mem_pair();
    test_serial();
    test_flush();
    test_set_wins();
    test_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
